// File: rtl/rv_decode_queue.sv
// RV32 instruction decoder feeding a DEPTH-entry record FIFO with valid/ready
// handshakes on both sides and a saturating count of illegal encodings.
module rv_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_fmt,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [2:0]                 out_func3,
  output logic [6:0]                 out_func7,
  output logic [XLEN-1:0]            out_imm,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [2:0]         d_fmt;
  logic signed [31:0] d_imm32;
  logic [XLEN-1:0]    d_imm;

  always_comb begin
    d_fmt   = FMT_ILL;
    d_imm32 = '0;
    if (in_instr[1:0] == 2'b11) begin
      unique case (in_instr[6:0])
        7'b0110011:                                     d_fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: d_fmt = FMT_I;
        7'b0100011:                                     d_fmt = FMT_S;
        7'b1100011:                                     d_fmt = FMT_B;
        7'b0110111, 7'b0010111:                         d_fmt = FMT_U;
        7'b1101111:                                     d_fmt = FMT_J;
        default:                                        d_fmt = FMT_ILL;
      endcase
    end
    case (d_fmt)
      FMT_I: d_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: d_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: d_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U: d_imm32 = {in_instr[31:12], 12'h000};
      FMT_J: d_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: d_imm32 = '0;
    endcase
    // Signed size cast carries the sign bit up to XLEN for both 32 and 64.
    d_imm = XLEN'(d_imm32);
  end

  logic [2:0]       mem_fmt   [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [XLEN-1:0]  mem_imm   [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [15:0]   illegal_q;
  logic          push, pop;
  logic [31:0]   head;

  assign in_ready    = (cnt_q != CW'(DEPTH));
  assign out_valid   = (cnt_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign count       = cnt_q;
  assign illegal_cnt = illegal_q;

  // Payload storage needs no reset: reads are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_fmt[wr_ptr]   <= d_fmt;
      mem_instr[wr_ptr] <= in_instr;
      mem_imm[wr_ptr]   <= d_imm;
      mem_tag[wr_ptr]   <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      illegal_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && d_fmt == FMT_ILL && illegal_q != 16'hFFFF)
        illegal_q <= illegal_q + 16'd1;
    end
  end

  assign head       = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_fmt    = out_valid ? mem_fmt[rd_ptr] : '0;
  assign out_imm    = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_tag    = out_valid ? mem_tag[rd_ptr] : '0;
  assign out_opcode = head[6:0];
  assign out_rd     = head[11:7];
  assign out_func3  = head[14:12];
  assign out_rs1    = head[19:15];
  assign out_rs2    = head[24:20];
  assign out_func7  = head[31:25];

endmodule

// File: tb/tb_rv_decode_queue.sv
// Scoreboard bench for rv_decode_queue: a 32-bit instance checked against a
// reference decoder, plus a 64-bit instance checked for sign extension.
module tb_rv_decode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        in_ready, out_valid;
  logic [2:0]  out_fmt, out_func3;
  logic [6:0]  out_opcode, out_func7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;
  logic [2:0]  count;
  logic [15:0] illegal_cnt;

  logic        v64 = 1'b0, r64 = 1'b0;
  logic [31:0] instr64 = '0;
  logic        in_ready64, out_valid64;
  logic [2:0]  fmt64, func3_64;
  logic [6:0]  opcode64, func7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [63:0] imm64;
  logic [7:0]  tag64;
  logic [2:0]  count64;
  logic [15:0] illegal64;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [63:0] imm;
    logic [7:0]  tag;
  } rec_t;

  rec_t sb[$];

  always #5 clk = ~clk;

  rv_decode_queue #(.XLEN(32), .DEPTH(4), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_fmt(out_fmt), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_tag(out_tag), .count(count), .illegal_cnt(illegal_cnt)
  );

  rv_decode_queue #(.XLEN(64), .DEPTH(4), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(in_ready64),
    .in_instr(instr64), .in_tag(8'h5A), .out_valid(out_valid64),
    .out_ready(r64), .out_fmt(fmt64), .out_opcode(opcode64),
    .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_func3(func3_64), .out_func7(func7_64), .out_imm(imm64),
    .out_tag(tag64), .count(count64), .illegal_cnt(illegal64)
  );

  function automatic rec_t model(input logic [31:0] w, input logic [7:0] t);
    rec_t r;
    logic signed [63:0] s;
    r.opcode = w[6:0];
    r.rd     = w[11:7];
    r.func3  = w[14:12];
    r.rs1    = w[19:15];
    r.rs2    = w[24:20];
    r.func7  = w[31:25];
    r.tag    = t;
    case (w[6:0])
      7'h33:                      r.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: r.fmt = 3'd1;
      7'h23:                      r.fmt = 3'd2;
      7'h63:                      r.fmt = 3'd3;
      7'h37, 7'h17:               r.fmt = 3'd4;
      7'h6F:                      r.fmt = 3'd5;
      default:                    r.fmt = 3'd7;
    endcase
    case (r.fmt)
      3'd1:    s = $signed(w[31:20]);
      3'd2:    s = $signed({w[31:25], w[11:7]});
      3'd3:    s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      3'd4:    s = $signed({w[31:12], 12'h000});
      3'd5:    s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: s = 64'sd0;
    endcase
    r.imm = s;
    return r;
  endfunction

  // Pops are committed at the following rising edge; compare the head now.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL pop_unexpected: DUT popped fmt=%0d tag=%h, scoreboard empty",
                 out_fmt, out_tag);
      end else begin
        rec_t e;
        e = sb.pop_front();
        if ({out_fmt, out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7,
             out_imm, out_tag} !==
            {e.fmt, e.opcode, e.rd, e.rs1, e.rs2, e.func3, e.func7,
             e.imm[31:0], e.tag})
          $display("FAIL pop_record: got fmt=%0d op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h tag=%h, want fmt=%0d op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h tag=%h",
                   out_fmt, out_opcode, out_rd, out_rs1, out_rs2, out_func3,
                   out_func7, out_imm, out_tag, e.fmt, e.opcode, e.rd, e.rs1,
                   e.rs2, e.func3, e.func7, e.imm[31:0], e.tag);
        else passed++;
      end
    end
  end

  task automatic push(input logic [31:0] w, input logic [7:0] t);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_instr = w;
    in_tag   = t;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end else begin
      sb.push_back(model(w, t));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int unsigned n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (count !== 3'd0 || sb.size() != 0)
      $display("FAIL drain: count=%0d sb=%0d, want 0 and 0", count, sb.size());
    else passed++;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({count, out_valid, in_ready, illegal_cnt, out_fmt, out_imm, out_tag} !==
        {3'd0, 1'b0, 1'b1, 16'd0, 3'd0, 32'd0, 8'd0})
      $display("FAIL reset_state: count=%0d ov=%b ir=%b ill=%0d fmt=%0d imm=%h tag=%h, want 0 0 1 0 0 0 0",
               count, out_valid, in_ready, illegal_cnt, out_fmt, out_imm, out_tag);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_upper;
    push(32'h0AA01EB7, 8'h11);
    total++;
    if ({out_valid, out_fmt, out_opcode, out_rd, out_imm, out_tag} !==
        {1'b1, 3'd4, 7'h37, 5'd29, 32'h0AA01000, 8'h11})
      $display("FAIL lui_head: ov=%b fmt=%0d op=%h rd=%0d imm=%h tag=%h, want 1 4 37 29 0aa01000 11",
               out_valid, out_fmt, out_opcode, out_rd, out_imm, out_tag);
    else passed++;
    pop_one();
  endtask

  task automatic test_formats;
    push(32'hFFF00093, 8'h21);
    total++;
    if ({out_fmt, out_imm} !== {3'd1, 32'hFFFFFFFF})
      $display("FAIL i_type: fmt=%0d imm=%h, want 1 ffffffff", out_fmt, out_imm);
    else passed++;
    pop_one();
    push(32'h00512423, 8'h22);
    total++;
    if ({out_fmt, out_rs1, out_rs2, out_func3, out_imm} !==
        {3'd2, 5'd2, 5'd5, 3'd2, 32'd8})
      $display("FAIL s_type: fmt=%0d rs1=%0d rs2=%0d f3=%0d imm=%h, want 2 2 5 2 8",
               out_fmt, out_rs1, out_rs2, out_func3, out_imm);
    else passed++;
    pop_one();
    push(32'hFE000EE3, 8'h23);
    total++;
    if ({out_fmt, out_imm} !== {3'd3, 32'hFFFFFFFC})
      $display("FAIL b_type: fmt=%0d imm=%h, want 3 fffffffc", out_fmt, out_imm);
    else passed++;
    pop_one();
    push(32'h8000006F, 8'h24);
    push(32'h40B50533, 8'h25);
    push(32'hFFC4A303, 8'h26);
    drain();
  endtask

  task automatic test_xlen64;
    logic [31:0] w  [4];
    logic [2:0]  ef [4];
    logic [63:0] ei [4];
    w[0] = 32'hFFF00093; ef[0] = 3'd1; ei[0] = 64'hFFFFFFFFFFFFFFFF;
    w[1] = 32'h00512423; ef[1] = 3'd2; ei[1] = 64'd8;
    w[2] = 32'hFE000EE3; ef[2] = 3'd3; ei[2] = 64'hFFFFFFFFFFFFFFFC;
    w[3] = 32'h8000006F; ef[3] = 3'd5; ei[3] = 64'hFFFFFFFFFFF00000;
    for (int i = 0; i < 4; i++) begin
      v64 = 1'b1;
      instr64 = w[i];
      @(negedge clk);
      v64 = 1'b0;
      total++;
      if ({out_valid64, fmt64, imm64} !== {1'b1, ef[i], ei[i]})
        $display("FAIL xlen64_%0d: ov=%b fmt=%0d imm=%h, want 1 %0d %h",
                 i, out_valid64, fmt64, imm64, ef[i], ei[i]);
      else passed++;
      r64 = 1'b1;
      @(negedge clk);
      r64 = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [9];
    for (int i = 0; i < 9; i++) w[i] = {8'(i * 37), 12'h0, 5'(i + 1), 7'h13};
    for (int i = 0; i < 4; i++) push(w[i], 8'(8'h40 + i));
    in_valid = 1'b1;
    in_instr = w[4];
    in_tag   = 8'h44;
    #1;
    total++;
    if ({in_ready, count} !== {1'b0, 3'd4})
      $display("FAIL full: in_ready=%b count=%0d, want 0 4", in_ready, count);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, count} !== {1'b1, 3'd3})
      $display("FAIL full_pop_only: in_ready=%b count=%0d, want 1 3", in_ready, count);
    else passed++;
    for (int i = 4; i < 9; i++) begin
      push(w[i], 8'(8'h40 + i));
      total++;
      if (count !== 3'd3)
        $display("FAIL steady_count_%0d: count=%0d, want 3", i, count);
      else passed++;
    end
    drain();
  endtask

  task automatic test_illegal;
    push(32'h00000000, 8'h61);
    push(32'h0000007F, 8'h62);
    total++;
    if ({out_fmt, out_imm, illegal_cnt} !== {3'd7, 32'd0, 16'd2})
      $display("FAIL illegal_pair: fmt=%0d imm=%h ill=%0d, want 7 0 2",
               out_fmt, out_imm, illegal_cnt);
    else passed++;
    drain();
    force dut.illegal_q = 16'hFFFE;
    @(negedge clk);
    release dut.illegal_q;
    push(32'h00000001, 8'h63);
    push(32'h0000000B, 8'h64);
    push(32'hFFFFFFF0, 8'h65);
    total++;
    if (illegal_cnt !== 16'hFFFF)
      $display("FAIL illegal_saturate: ill=%h, want ffff", illegal_cnt);
    else passed++;
    drain();
  endtask

  task automatic test_mid_reset;
    push(32'h00100093, 8'h71);
    push(32'h00200113, 8'h72);
    push(32'h00000000, 8'h73);
    total++;
    if (count !== 3'd3)
      $display("FAIL prefill: count=%0d, want 3", count);
    else passed++;
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    total++;
    if ({count, out_valid, in_ready, illegal_cnt, out_tag} !==
        {3'd0, 1'b0, 1'b1, 16'd0, 8'd0})
      $display("FAIL mid_reset: count=%0d ov=%b ir=%b ill=%0d tag=%h, want 0 0 1 0 0",
               count, out_valid, in_ready, illegal_cnt, out_tag);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    push(32'h0AA01EB7, 8'h99);
    total++;
    if ({count, out_tag, out_fmt} !== {3'd1, 8'h99, 3'd4})
      $display("FAIL post_reset_head: count=%0d tag=%h fmt=%0d, want 1 99 4",
               count, out_tag, out_fmt);
    else passed++;
    pop_one();
    total++;
    if ({out_valid, out_fmt, out_opcode, out_imm, out_tag} !== '0)
      $display("FAIL empty_zero: ov=%b fmt=%0d op=%h imm=%h tag=%h, want all 0",
               out_valid, out_fmt, out_opcode, out_imm, out_tag);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_upper();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_decode_queue.md
# rv_decode_queue

Parametrised RV32 instruction-decode stage with an output queue. It splits each accepted 32-bit instruction word into the R/I/S/B/U/J overlay views, classifies its format and sign-extends the immediate to XLEN. Each decoded record is buffered in a DEPTH-entry FIFO behind a valid/ready handshake. It sits between instruction fetch and the register-read stage and keeps a saturating count of illegal encodings.

## Interface
- XLEN, 32: immediate output width; 32 or 64 only.
- DEPTH, 4: queue entries; power of two, ≥2.
- TAG_W, 8: width of the opaque tag carried with each instruction.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers in_instr/in_tag.
- in_ready  out  1  queue can accept; equals !full.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  tag, returned unchanged with the record.
- out_valid  out  1  head record present (!empty).
- out_ready  in  1  downstream consumes head.
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7  out  7,5,5,5,3,7  raw bit fields of the head instruction.
- out_imm  out  XLEN  sign-extended immediate of the head instruction.
- out_tag  out  TAG_W  tag of the head instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.
- illegal_cnt  out  16  saturating count of accepted illegal instructions.

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both may occur in the same cycle, and count is then unchanged.
- Decode is combinational on in_instr; the decoded record is written into the FIFO, so no decode logic follows the queue.
- Format by opcode. Any other opcode is ILLEGAL, and so is any word with in_instr[1:0] != 2'b11:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
- Raw fields are taken from fixed bit positions regardless of format: opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20], func7 [31:25].
- Immediates, sign bit instr[31] extended to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and ILLEGAL: imm = 0.
- illegal_cnt increments by 1 on each push of an ILLEGAL record and saturates at 16'hFFFF.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- When empty, all out_* data fields read 0.

## Timing
- Latency 1: a record pushed at edge N is visible with out_valid=1 after edge N.
- No bypass: when empty, a push and a pop in the same cycle cannot occur.
- When full, in_ready=0 even if out_ready=1. A push is accepted in the cycle after the pop frees an entry.
- out_* data changes only on a pop, or on a push into an empty queue.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, out_valid=0, in_ready=1, illegal_cnt=0, pointers=0, out_* data=0.
  - Queued records are discarded.
  - The first push is accepted on the first rising edge after rst deasserts.

## Test plan
- Push 0x0AA01EB7 with tag 0x11 → next cycle: out_fmt=4, out_opcode=0x37, out_rd=29, out_imm=0x0AA01000, out_tag=0x11.
- Push 0xFFF00093, then 0x00512423, then 0xFE000EE3:
  - 0xFFF00093 → I, imm=all ones.
  - 0x00512423 → S, rs1=2, rs2=5, func3=2, imm=8.
  - 0xFE000EE3 → B, imm=-4.
  - Repeat the sequence with XLEN=64 and check sign extension to 64 bits.
- DEPTH=4 with out_ready=0: push 5 words → in_ready drops after the 4th push, count=4. Then assert out_ready with in_valid held → one pop and one push per cycle, and records drain in FIFO order across pointer wrap.
- Push 0x00000000 and 0x0000007F → both out_fmt=7, out_imm=0, illegal_cnt=2. Force illegal_cnt to 0xFFFE and push 3 illegal words → count stops at 0xFFFF.
- Fill to 3 entries, then pulse rst mid-cycle → immediately count=0, out_valid=0, illegal_cnt=0. The next push after release appears alone at the head.
